// File: rtl/hazard_unit_pkg.sv
// Shared core definitions for the hazard unit slice.
//   REG_W     register-index width
//   REG_ZERO  x0 index; never produces a dependence
//   fsm_state_t  memory-wait FSM states {RUN, WAIT}
//   reg_hit() true when a non-zero destination matches either source
package hazard_unit_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fsm_state_t;

  function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs1,
                                   input logic [REG_W-1:0] rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle of the hazard controller.
//   master: pipeline/datapath (drives operand indices, stage flags, dmem status)
//   slave : hazard_unit (drives stall/flush controls, counters, mem_err)
// Data-memory handshake: dmem_req_M marks an access held in M; the access
// completes in the cycle where dmem_req_M and dmem_ready_M are both 1. Any
// cycle with dmem_req_M=1 and dmem_ready_M=0 is a wait cycle.
interface hazard_unit_if #(parameter int CNT_W = 32) ();
  import hazard_unit_pkg::*;

  logic [REG_W-1:0] RS1D, RS2D, WriteRegE, WriteRegM;
  logic             RegWriteE, MemtoRegE, MemtoRegM, BranchD, PCSrcD;
  logic             dmem_req_M, dmem_ready_M, perf_clr;
  logic             StallF, StallD, FlushD, FlushE, StallE, StallM, StallW;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_err;

  modport master (
    output RS1D, RS2D, WriteRegE, WriteRegM, RegWriteE, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, dmem_req_M, dmem_ready_M, perf_clr,
    input  StallF, StallD, FlushD, FlushE, StallE, StallM, StallW,
           stall_cnt, flush_cnt, mem_err
  );

  modport slave (
    input  RS1D, RS2D, WriteRegE, WriteRegM, RegWriteE, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, dmem_req_M, dmem_ready_M, perf_clr,
    output StallF, StallD, FlushD, FlushE, StallE, StallM, StallW,
           stall_cnt, flush_cnt, mem_err
  );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst (async, active-high), clr (sync, beats inc), inc, cnt[W]
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage core (decode/execute boundary).
//   clk, rst      core clock, async active-high reset
//   bus (slave)   hazard inputs, stall/flush outputs, perf counters, mem_err
//   state_dbg     memory-wait FSM state
//   wait_cnt_dbg  cycles spent in the current memory wait (saturating)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  bus,
  output fsm_state_t    state_dbg,
  output logic [15:0]   wait_cnt_dbg
);
  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  logic lwstall, brstall, memstall, any_stall;

  assign lwstall  = bus.MemtoRegE & reg_hit(bus.WriteRegE, bus.RS1D, bus.RS2D);
  assign brstall  = bus.BranchD &
                    ((bus.RegWriteE & reg_hit(bus.WriteRegE, bus.RS1D, bus.RS2D)) |
                     (bus.MemtoRegM & reg_hit(bus.WriteRegM, bus.RS1D, bus.RS2D)));
  assign memstall = bus.dmem_req_M & ~bus.dmem_ready_M;
  assign any_stall = lwstall | brstall | memstall;

  assign bus.StallF = any_stall;
  assign bus.StallD = any_stall;
  assign bus.StallE = memstall;
  assign bus.StallM = memstall;
  assign bus.StallW = memstall;
  // A held D/E register must not also take a bubble.
  assign bus.FlushE = (lwstall | brstall) & ~memstall;
  // A taken branch only discards the fetched instruction when D advances.
  assign bus.FlushD = bus.PCSrcD & ~any_stall;

  // Memory-wait FSM
  fsm_state_t  state, state_n;
  logic [15:0] wait_cnt, wait_n;
  logic        mem_err_q, mem_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      mem_err_q <= mem_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    mem_err_n = mem_err_q;
    if (state == WAIT && wait_cnt == TIMEOUT) mem_err_n = 1'b1;
    case (state)
      RUN: begin
        if (memstall) begin
          state_n = WAIT;
          wait_n  = 16'd1;
        end
      end
      WAIT: begin
        // Completion and a dropped request (protocol abort) both leave WAIT;
        // neither raises an error by itself.
        if (bus.dmem_ready_M || !bus.dmem_req_M) begin
          state_n = RUN;
          wait_n  = '0;
        end else if (wait_cnt != TIMEOUT) begin
          wait_n = wait_cnt + 16'd1;
        end
      end
      default: begin
        state_n = RUN;
        wait_n  = '0;
      end
    endcase
  end

  assign bus.mem_err   = mem_err_q;
  assign state_dbg     = state;
  assign wait_cnt_dbg  = wait_cnt;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .clr (bus.perf_clr), .inc (any_stall),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .clr (bus.perf_clr), .inc (bus.FlushD),
    .cnt (bus.flush_cnt)
  );
endmodule
